disp_arbiter: RTL and testbench
===============================

# disp_arbiter

Round-robin arbiter that shares the board's 8-bit LED bank between up to N_REQ self-test requesters. Each granted requester owns the display for a fixed dwell time measured in milliseconds. The arbiter then pulses `done` and hands the display to the next requester. It sits between the board-check test engines and the `led_display_o` pins, and applies the board's LED polarity.

## Interface
- `CLK_IN_MHZ`, default 125: system clock frequency in MHz. One millisecond is CLK_IN_MHZ*1000 cycles.
- `N_REQ`, default 4: number of requesters, valid range 1..8.
- `DWELL_MS`, default 500: display ownership time per grant, in ms, ≥1.
- `LED_POLARITY`, default 1'b1: 1 means LEDs are active-high; 0 means the output is inverted.
- `clk_i`, in, 1: system clock. This is the only clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `req_i`, in, N_REQ: per-requester level request, held high until `done_o` or abandoned.
- `data_i`, in, 8*N_REQ: per-requester pattern; byte k is `data_i[8k+7:8k]`.
- `grant_o`, out, N_REQ: one-hot grant, registered.
- `done_o`, out, N_REQ: one-cycle pulse to the owner when its dwell completes.
- `owner_o`, out, max(1,$clog2(N_REQ)): index of the current or last owner.
- `busy_o`, out, 1: high in SHOW and GAP.
- `led_display_o`, out, 8: LED drive, registered.

## Operation
- The FSM has three states: IDLE, SHOW and GAP.
- **IDLE:** the LEDs show the off pattern. This is 8'h00 when LED_POLARITY=1 and 8'hFF when it is 0.
  - If any `req_i` bit is high, the winner is the first requester at or after the rotating pointer `rr_ptr`, searching upward modulo N_REQ.
  - On the next edge the arbiter registers the grant, latches the winner's `data_i` byte, clears the dwell counters and moves to SHOW.
  - `rr_ptr` is set to (winner+1) mod N_REQ.
- **SHOW:** `led_display_o` = latched byte XOR {8{~LED_POLARITY}}.
  - A millisecond prescaler counts 0..CLK_IN_MHZ*1000-1.
  - A ms counter counts prescaler wraps.
  - When the ms counter reaches DWELL_MS, the arbiter moves to GAP.
- **Dwell end:** on the edge entering GAP, `grant_o` goes to 0 and `done_o[owner]` pulses for exactly that one cycle.
- **Abandon:** if `req_i[owner]` is low in SHOW, the arbiter moves to GAP on the next edge with no `done_o` pulse.
- **GAP:** one cycle with the LEDs off and no grant, then return to IDLE. This guarantees a visible blank between owners.
- **Data latching:** changes on `data_i` during SHOW are ignored.
- **N_REQ=1:** the same requester is re-granted after every GAP while its request stays high.
- **Counter widths:** counters are sized with $clog2 of their terminal count +1. No wrap-around is permitted inside SHOW.

## Timing
- **Reset values:** `grant_o`=0, `done_o`=0, `owner_o`=0, `busy_o`=0, `led_display_o`=off pattern, `rr_ptr`=0, state=IDLE.
- **Request to grant:** one cycle from `req_i` sampled high in IDLE to `grant_o` and the new `led_display_o` both visible.
- **Dwell length:** exactly DWELL_MS*CLK_IN_MHZ*1000 cycles from the grant edge to the GAP edge.
- **Back-to-back grants:** if a request is pending, the minimum spacing between successive grants is dwell + 2 cycles (GAP plus IDLE).
- **Request drop at dwell end:** if `req_i[owner]` drops in the same cycle as dwell completion, completion wins and `done_o` pulses.
- **Reset mid-SHOW:** all outputs return to their reset values immediately, asynchronously, and no `done_o` pulse is produced.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- **Package `disp_arb_pkg`:** holds `disp_state_e` {IDLE, SHOW, GAP}, a function returning the LED off pattern for a given polarity, and the localparam expression for the cycles-per-ms width.
- **Sub-module `ms_tick_gen`** (parameter CLK_IN_MHZ; ports `clk_i`, `rst_i`, `clr_i`, `tick_o`):
  - emits a one-cycle `tick_o` every CLK_IN_MHZ*1000 cycles;
  - is synchronously cleared by `clr_i`;
  - is reusable by the other board-check timers.
- The round-robin search and the FSM live in `disp_arbiter`.

## Test plan
Use CLK_IN_MHZ=1, DWELL_MS=2 (dwell = 2000 cycles) and N_REQ=4 unless noted.
- **Reset:** assert `rst_i` mid-cycle → outputs at reset values, LEDs=8'h00; with LED_POLARITY=0 → LEDs=8'hFF.
- **Single request:** `req_i`=4'b0100 with byte2=8'hA5 → next cycle `grant_o`=4'b0100, `owner_o`=2, LEDs=8'hA5; `done_o`=4'b0100 pulses 2000 cycles later; LEDs=00 in GAP.
- **Round-robin:** all four requests held high → grant order 0,1,2,3,0, each grant separated by 2002 cycles, each followed by its `done_o`.
- **Abandon:** drop `req_i[1]` 100 cycles into its SHOW → grant clears next edge, no `done_o`, requester 2 granted 2 cycles later.
- **Collision:** `req_i[owner]` drops on the exact dwell-completion cycle → `done_o` still pulses once.
- **Data stability:** change byte0 from 8'h3C to 8'hFF during SHOW → LEDs remain 8'h3C.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// disp_arb_pkg: shared FSM states, counter sizing and LED polarity helpers
package disp_arb_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} disp_state_e;

    localparam int CYC_PER_MHZ_MS = 1000;

    function automatic int cnt_width(input int term);
        return term < 1 ? 1 : $clog2(term + 1);
    endfunction

    function automatic int ms_cnt_width(input int clk_in_mhz);
        return cnt_width(clk_in_mhz * CYC_PER_MHZ_MS);
    endfunction

    function automatic logic [7:0] led_off(input logic pol);
        return pol ? 8'h00 : 8'hFF;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-cycle tick every millisecond, synchronously clearable
module ms_tick_gen
    import disp_arb_pkg::*;
#(
    parameter int CLK_IN_MHZ = 125
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int TERM = CLK_IN_MHZ * CYC_PER_MHZ_MS;
    localparam int W = ms_cnt_width(CLK_IN_MHZ);

    logic [W-1:0] cnt;

    assign tick_o = cnt == W'(TERM - 1);

    // prescaler counts 0..TERM-1 and restarts from zero on clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else
            cnt <= (clr_i || tick_o) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin owner of the LED bank with a fixed ms dwell per grant
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter int   CLK_IN_MHZ   = 125,
    parameter int   N_REQ        = 4,
    parameter int   DWELL_MS     = 500,
    parameter logic LED_POLARITY = 1'b1,
    localparam int  OW           = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [8*N_REQ-1:0] data_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [OW-1:0]      owner_o,
    output logic               busy_o,
    output logic [7:0]         led_display_o
);

    localparam int MW = cnt_width(DWELL_MS);
    localparam logic [7:0] OFF = led_off(LED_POLARITY);
    localparam logic [7:0] MASK = {8{~LED_POLARITY}};

    disp_state_e state, state_n;
    logic [OW-1:0] rr_ptr, ptr_n, win, cand, owner_n;
    logic [N_REQ-1:0] grant_n, done_n;
    logic [7:0] led_n, win_byte;
    logic [MW-1:0] ms_cnt;
    logic found, tick, tick_clr, dwell_done;

    assign tick_clr = state != SHOW;
    assign dwell_done = tick && ms_cnt == MW'(DWELL_MS - 1);

    ms_tick_gen #(.CLK_IN_MHZ(CLK_IN_MHZ)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    // first requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        found = 1'b0;
        win = '0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = OW'((int'(rr_ptr) + i) % N_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
    end

    // pattern byte of the winning requester
    always_comb begin
        win_byte = data_i[7:0];
        for (int k = 0; k < N_REQ; k++)
            if (win == OW'(k)) win_byte = data_i[8*k +: 8];
    end

    // count whole milliseconds of the current dwell; idle outside SHOW
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ms_cnt <= '0;
        else
            ms_cnt <= tick_clr ? '0 : ms_cnt + MW'(tick);
    end

    // next state and next registered outputs; completion beats abandon
    always_comb begin
        state_n = state;
        grant_n = grant_o;
        done_n = '0;
        owner_n = owner_o;
        led_n = led_display_o;
        ptr_n = rr_ptr;
        case (state)
            IDLE: begin
                grant_n = '0;
                led_n = OFF;
                if (|req_i) begin
                    state_n = SHOW;
                    grant_n = N_REQ'(1) << win;
                    owner_n = win;
                    led_n = win_byte ^ MASK;
                    ptr_n = OW'((int'(win) + 1) % N_REQ);
                end
            end
            SHOW: begin
                if (dwell_done || !req_i[owner_o]) begin
                    state_n = GAP;
                    grant_n = '0;
                    led_n = OFF;
                    done_n = dwell_done ? N_REQ'(1) << owner_o : '0;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                led_n = OFF;
            end
        endcase
    end

    // state, pointer and all outputs registered together
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant_o <= '0;
            done_o <= '0;
            owner_o <= '0;
            busy_o <= 1'b0;
            led_display_o <= OFF;
        end else begin
            state <= state_n;
            rr_ptr <= ptr_n;
            grant_o <= grant_n;
            done_o <= done_n;
            owner_o <= owner_n;
            busy_o <= state_n != IDLE;
            led_display_o <= led_n;
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: scoreboard bench for the round-robin LED arbiter
module tb_disp_arbiter;

    localparam int LIM = 3000;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] owner;
        logic [7:0] led;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic [3:0] req_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0] grant_o, done_o, grant_b, done_b;
    logic [1:0] owner_o, owner_b;
    logic busy_o, busy_b;
    logic [7:0] led_display_o, led_b;

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];
    logic [3:0] done_q[$];

    always #5 clk = ~clk;

    disp_arbiter #(.CLK_IN_MHZ(1), .N_REQ(4), .DWELL_MS(2), .LED_POLARITY(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
        .grant_o(grant_o), .done_o(done_o), .owner_o(owner_o),
        .busy_o(busy_o), .led_display_o(led_display_o)
    );

    disp_arbiter #(.CLK_IN_MHZ(1), .N_REQ(4), .DWELL_MS(2), .LED_POLARITY(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
        .grant_o(grant_b), .done_o(done_b), .owner_o(owner_b),
        .busy_o(busy_b), .led_display_o(led_b)
    );

    task automatic wait_grant(output int n);
        n = 0;
        while (grant_o == '0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done_o == '0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        #13;
        vectors++;
        if ({grant_o, done_o, owner_o, busy_o, led_display_o} !== {4'b0, 4'b0, 2'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_outs: got %h want %h", {grant_o, done_o, owner_o, busy_o, led_display_o}, 19'h0);
        end
        vectors++;
        if (led_b !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_led_inv: got %h want ff", led_b);
        end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int n;
        exp_t e;
        logic [3:0] d;
        data_i[23:16] = 8'hA5;
        req_i = 4'b0100;
        exp_q.push_back({4'b0100, 2'd2, 8'hA5});
        done_q.push_back(4'b0100);
        wait_grant(n);
        e = exp_q.pop_front();
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL single_latency: got %0d want 1", n);
        end
        vectors++;
        if ({grant_o, owner_o, led_display_o} !== e) begin
            miscompares++;
            $display("FAIL single_grant: got %h want %h", {grant_o, owner_o, led_display_o}, e);
        end
        vectors++;
        if (led_b !== ~e.led) begin
            miscompares++;
            $display("FAIL single_led_inv: got %h want %h", led_b, ~e.led);
        end
        wait_done(n);
        d = done_q.pop_front();
        vectors++;
        if (n !== 2000) begin
            miscompares++;
            $display("FAIL single_dwell: got %0d want 2000", n);
        end
        vectors++;
        if ({done_o, grant_o, busy_o, led_display_o} !== {d, 4'b0, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL single_done: got %h want %h", {done_o, grant_o, busy_o, led_display_o}, {d, 4'b0, 1'b1, 8'h00});
        end
        req_i = '0;
        @(negedge clk);
        vectors++;
        if ({done_o, busy_o, led_display_o} !== {4'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL single_idle: got %h want 0", {done_o, busy_o, led_display_o});
        end
    endtask

    task automatic test_round_robin;
        int n;
        exp_t e;
        logic [3:0] d;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        data_i = {8'h44, 8'h33, 8'h22, 8'h11};
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({4'b0001 << (i % 4), 2'(i % 4), 8'h11 * 8'((i % 4) + 1)});
            done_q.push_back(4'b0001 << (i % 4));
        end
        for (int i = 0; i < 5; i++) begin
            wait_grant(n);
            e = exp_q.pop_front();
            vectors++;
            if (n !== (i == 0 ? 1 : 2)) begin
                miscompares++;
                $display("FAIL rr_gap%0d: got %0d want %0d", i, n, i == 0 ? 1 : 2);
            end
            vectors++;
            if ({grant_o, owner_o, led_display_o} !== e) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %h want %h", i, {grant_o, owner_o, led_display_o}, e);
            end
            wait_done(n);
            d = done_q.pop_front();
            vectors++;
            if (n !== 2000 || done_o !== d) begin
                miscompares++;
                $display("FAIL rr_done%0d: got %0d/%b want 2000/%b", i, n, done_o, d);
            end
        end
        req_i = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abandon;
        int n;
        exp_t e;
        req_i = 4'b0110;
        exp_q.push_back({4'b0010, 2'd1, 8'h22});
        exp_q.push_back({4'b0100, 2'd2, 8'h33});
        wait_grant(n);
        e = exp_q.pop_front();
        vectors++;
        if (n !== 1 || {grant_o, owner_o, led_display_o} !== e) begin
            miscompares++;
            $display("FAIL abandon_grant1: got %0d/%h want 1/%h", n, {grant_o, owner_o, led_display_o}, e);
        end
        repeat (100) @(negedge clk);
        req_i = 4'b0100;
        @(negedge clk);
        vectors++;
        if ({grant_o, done_o, busy_o, led_display_o} !== {4'b0, 4'b0, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL abandon_clear: got %h want %h", {grant_o, done_o, busy_o, led_display_o}, {4'b0, 4'b0, 1'b1, 8'h00});
        end
        wait_grant(n);
        e = exp_q.pop_front();
        vectors++;
        if (n !== 2 || {grant_o, owner_o, led_display_o} !== e) begin
            miscompares++;
            $display("FAIL abandon_next: got %0d/%h want 2/%h", n, {grant_o, owner_o, led_display_o}, e);
        end
        req_i = '0;
        @(negedge clk);
        vectors++;
        if ({grant_o, done_o, busy_o} !== {4'b0, 4'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL abandon_nodone: got %h want %h", {grant_o, done_o, busy_o}, {4'b0, 4'b0, 1'b1});
        end
        @(negedge clk);
    endtask

    task automatic test_collision;
        int n;
        exp_t e;
        logic [3:0] d;
        req_i = 4'b1000;
        exp_q.push_back({4'b1000, 2'd3, 8'h44});
        done_q.push_back(4'b1000);
        wait_grant(n);
        e = exp_q.pop_front();
        vectors++;
        if (n !== 1 || {grant_o, owner_o, led_display_o} !== e) begin
            miscompares++;
            $display("FAIL coll_grant: got %0d/%h want 1/%h", n, {grant_o, owner_o, led_display_o}, e);
        end
        repeat (1999) @(negedge clk);
        vectors++;
        if ({grant_o, done_o} !== {4'b1000, 4'b0}) begin
            miscompares++;
            $display("FAIL coll_show: got %h want %h", {grant_o, done_o}, {4'b1000, 4'b0});
        end
        req_i = '0;
        @(negedge clk);
        d = done_q.pop_front();
        vectors++;
        if ({done_o, grant_o} !== {d, 4'b0}) begin
            miscompares++;
            $display("FAIL coll_done: got %h want %h", {done_o, grant_o}, {d, 4'b0});
        end
        @(negedge clk);
        vectors++;
        if (done_o !== 4'b0) begin
            miscompares++;
            $display("FAIL coll_pulse_once: got %b want 0000", done_o);
        end
    endtask

    task automatic test_data_stable;
        int n;
        exp_t e;
        logic [3:0] d;
        data_i[7:0] = 8'h3C;
        req_i = 4'b0001;
        exp_q.push_back({4'b0001, 2'd0, 8'h3C});
        done_q.push_back(4'b0001);
        wait_grant(n);
        e = exp_q.pop_front();
        vectors++;
        if (n !== 1 || {grant_o, owner_o, led_display_o} !== e) begin
            miscompares++;
            $display("FAIL data_grant: got %0d/%h want 1/%h", n, {grant_o, owner_o, led_display_o}, e);
        end
        @(negedge clk);
        data_i[7:0] = 8'hFF;
        repeat (50) @(negedge clk);
        vectors++;
        if (led_display_o !== 8'h3C) begin
            miscompares++;
            $display("FAIL data_hold: got %h want 3c", led_display_o);
        end
        wait_done(n);
        d = done_q.pop_front();
        vectors++;
        if (n !== 1949 || {done_o, led_display_o} !== {d, 8'h00}) begin
            miscompares++;
            $display("FAIL data_done: got %0d/%h want 1949/%h", n, {done_o, led_display_o}, {d, 8'h00});
        end
        req_i = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_show;
        int n;
        exp_t e;
        req_i = 4'b0001;
        exp_q.push_back({4'b0001, 2'd0, 8'hFF});
        wait_grant(n);
        e = exp_q.pop_front();
        vectors++;
        if (n !== 1 || {grant_o, owner_o, led_display_o} !== e) begin
            miscompares++;
            $display("FAIL rst_show_grant: got %0d/%h want 1/%h", n, {grant_o, owner_o, led_display_o}, e);
        end
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        vectors++;
        if ({grant_o, done_o, owner_o, busy_o, led_display_o, led_b} !== {4'b0, 4'b0, 2'b0, 1'b0, 8'h00, 8'hFF}) begin
            miscompares++;
            $display("FAIL rst_show_async: got %h want %h", {grant_o, done_o, owner_o, busy_o, led_display_o, led_b},
                     {4'b0, 4'b0, 2'b0, 1'b0, 8'h00, 8'hFF});
        end
        @(negedge clk);
        req_i = '0;
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({grant_o, done_o, busy_o} !== {4'b0, 4'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_show_after: got %h want 0", {grant_o, done_o, busy_o});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_abandon;
        test_collision;
        test_data_stable;
        test_reset_mid_show;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
